// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 block padder: block geometry, padding
// constants, MD5 initial chaining values and the padder state encoding.
package md5_pkg;

   localparam int unsigned BLOCK_W     = 512;
   localparam int unsigned WORDS       = 16;
   localparam int unsigned LEN_WORD_LO = 14;
   localparam int unsigned LEN_WORD_HI = 15;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;

   localparam logic [31:0] MD5_IV_A = 32'h67452301;
   localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
   localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
   localparam logic [31:0] MD5_IV_D = 32'h10325476;

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      EXTRA
   } pad_state_t;

   // Byte counts above 4 are treated as a full word.
   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/md5_pad_lane.sv
// Combinational tail-word formatter for the MD5 padder.
// Keeps the first 'count' bytes of data, places the 0x80 pad byte directly
// after them and zeroes the rest. When the word is full the pad byte does
// not fit and ovf tells the caller to put it in the following word.
// Ports:
//   data  in  32  raw word, earliest byte in [7:0]
//   bytes in  3   valid byte count (values above 4 clamp to 4)
//   word  out 32  masked word with pad byte inserted
//   count out 3   clamped byte count
//   ovf   out 1   pad byte belongs to the next word
module md5_pad_lane
   import md5_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  bytes,
   output logic [31:0] word,
   output logic [2:0]  count,
   output logic        ovf
);

   always_comb begin
      count = clamp_bytes(bytes);
      word  = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         if (b < 32'(count)) begin
            word[8*b +: 8] = data[8*b +: 8];
         end else if (b == 32'(count)) begin
            word[8*b +: 8] = PAD_BYTE;
         end
      end
      ovf = (count == 3'd4);
   end

endmodule

// File: rtl/md5_block_padder.sv
// MD5 block padder: packs a little-endian 32-bit word stream into 512-bit
// blocks, appends 0x80, zero fill and the 64-bit message bit length, and
// emits a second length-only block when the length does not fit.
// Ports:
//   clock        in   1    rising-edge clock
//   reset_n      in   1    asynchronous active-low reset
//   in_valid     in   1    input word valid
//   in_ready     out  1    padder accepts a word
//   in_data      in   32   message bytes, earliest byte in [7:0]
//   in_bytes     in   3    valid bytes (4 for non-last words, 0..4 on last)
//   in_last      in   1    final word of the message
//   block_valid  out  1    block_data holds a complete block
//   block_ready  in   1    consumer accepts the block
//   block_data   out  512  word i at [32*i+31:32*i]
//   block_last   out  1    final (length-carrying) block of the message
//   abort        in   1    only with MD5_PAD_ABORT_EN: drop the message in progress
// Build option: define MD5_PAD_ABORT_EN to add the abort input.
module md5_block_padder
   import md5_pkg::*;
#(
   parameter int unsigned LEN_W = 64
)
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic [2:0]         in_bytes,
   input  logic               in_last,
   output logic               block_valid,
   input  logic               block_ready,
   output logic [BLOCK_W-1:0] block_data,
   output logic               block_last
`ifdef MD5_PAD_ABORT_EN
   ,
   input  logic               abort
`endif
);

   pad_state_t state, state_nx;

   logic [31:0]      words_q [WORDS];
   logic [4:0]       idx;
   logic [LEN_W-1:0] len;
   logic             pend_extra;
   logic             pend_pad;
   logic             last_q;
   logic             ready_q;

   logic [31:0]      lane_word;
   logic [2:0]       lane_cnt;
   logic             lane_ovf;

   logic             accept;
   logic             abort_now;
   logic [3:0]       wi;
   logic [3:0]       wi_p1;
   logic [6:0]       pad_pos;
   logic             fits;
   logic [LEN_W-1:0] len_sum;
   logic [63:0]      len_new64;
   logic [63:0]      len_cur64;

   md5_pad_lane u_lane (
      .data  (in_data),
      .bytes (in_bytes),
      .word  (lane_word),
      .count (lane_cnt),
      .ovf   (lane_ovf)
   );

`ifdef MD5_PAD_ABORT_EN
   assign abort_now = abort;
`else
   assign abort_now = 1'b0;
`endif

   // ready_q is only ever set while in FILL, so it doubles as the state gate.
   assign accept    = in_valid & ready_q;
   assign wi        = idx[3:0];
   assign wi_p1     = wi + 4'd1;
   // Byte position of the 0x80 marker within the current block.
   assign pad_pos   = {idx, 2'b00} + 7'(lane_cnt);
   assign fits      = (pad_pos <= 7'd55);
   assign len_sum   = len + LEN_W'({lane_cnt, 3'b000});
   assign len_new64 = 64'(len_sum);
   assign len_cur64 = 64'(len);

   always_comb begin
      state_nx = state;
      case (state)
         FILL: begin
            if (accept) begin
               if (in_last) begin
                  state_nx = EMIT;
               end else if ((lane_cnt != 3'd0) && (wi == 4'd15)) begin
                  state_nx = EMIT;
               end
            end
         end
         EMIT: begin
            if (block_ready) begin
               state_nx = pend_extra ? EXTRA : FILL;
            end
         end
         EXTRA: state_nx = EMIT;
         default: state_nx = FILL;
      endcase
      if (abort_now) begin
         state_nx = FILL;
      end
   end

   // in_ready is registered so it stays low throughout reset and rises on
   // the first edge after release; it always equals (state == FILL) after that.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= FILL;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx == FILL);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         words_q    <= '{default: '0};
         idx        <= '0;
         len        <= '0;
         pend_extra <= 1'b0;
         pend_pad   <= 1'b0;
         last_q     <= 1'b0;
      end else if (abort_now) begin
         words_q    <= '{default: '0};
         idx        <= '0;
         len        <= '0;
         pend_extra <= 1'b0;
         pend_pad   <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  if (!in_last) begin
                     if (lane_cnt != 3'd0) begin
                        words_q[wi] <= in_data;
                        idx         <= idx + 5'd1;
                        len         <= len_sum;
                     end
                  end else begin
                     words_q[wi] <= lane_word;
                     idx         <= idx + 5'd1;
                     len         <= len_sum;
                     if (lane_ovf && (wi != 4'd15)) begin
                        words_q[wi_p1] <= {24'h000000, PAD_BYTE};
                     end
                     // When the marker fits, idx <= 13, so the data/marker
                     // words never collide with the length words.
                     if (fits) begin
                        words_q[4'(LEN_WORD_LO)] <= len_new64[31:0];
                        words_q[4'(LEN_WORD_HI)] <= len_new64[63:32];
                        last_q                   <= 1'b1;
                     end else begin
                        last_q     <= 1'b0;
                        pend_extra <= 1'b1;
                        pend_pad   <= lane_ovf && (wi == 4'd15);
                     end
                  end
               end
            end
            EMIT: begin
               if (block_ready) begin
                  words_q <= '{default: '0};
                  idx     <= '0;
                  last_q  <= 1'b0;
                  if (last_q) begin
                     len <= '0;
                  end
               end
            end
            EXTRA: begin
               words_q[0]               <= pend_pad ? {24'h000000, PAD_BYTE} : 32'h0;
               words_q[4'(LEN_WORD_LO)] <= len_cur64[31:0];
               words_q[4'(LEN_WORD_HI)] <= len_cur64[63:32];
               last_q                   <= 1'b1;
               pend_extra               <= 1'b0;
               pend_pad                 <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < WORDS; g++) begin : g_out
      assign block_data[32*g +: 32] = words_q[g];
   end

   assign in_ready    = ready_q;
   assign block_valid = (state == EMIT);
   assign block_last  = last_q;

endmodule
